// File: rtl/no_syk_multi_if.sv
// Interface for one multi-valued tortoise/hare node: the control/data inputs
// driven by the network and the state, match and step-count outputs of the node.
// Optional period outputs exist only when NO_SYK_PERIOD_EN is defined.
// Ports: master = network side (drives inputs), slave = node side.
interface no_syk_multi_if #(
  parameter int STATE_W = 1,
  parameter int CNT_W   = 16
);
  logic               reset_nos;
  logic [STATE_W-1:0] init_state;
  logic               start_s0;
  logic               start_s1;
  logic [STATE_W-1:0] il2r_s0;
  logic [STATE_W-1:0] il2r_s1;
  logic [STATE_W-1:0] s0;
  logic [STATE_W-1:0] s1;
  logic [STATE_W-1:0] syk_s0;
  logic [STATE_W-1:0] syk_s1;
  logic               match;
  logic [CNT_W-1:0]   steps;
  logic               steps_sat;
`ifdef NO_SYK_PERIOD_EN
  logic [CNT_W-1:0]   period;
  logic               period_valid;

  modport master (
    output reset_nos, init_state, start_s0, start_s1, il2r_s0, il2r_s1,
    input  s0, s1, syk_s0, syk_s1, match, steps, steps_sat, period, period_valid
  );
  modport slave (
    input  reset_nos, init_state, start_s0, start_s1, il2r_s0, il2r_s1,
    output s0, s1, syk_s0, syk_s1, match, steps, steps_sat, period, period_valid
  );
`else
  modport master (
    output reset_nos, init_state, start_s0, start_s1, il2r_s0, il2r_s1,
    input  s0, s1, syk_s0, syk_s1, match, steps, steps_sat
  );
  modport slave (
    input  reset_nos, init_state, start_s0, start_s1, il2r_s0, il2r_s1,
    output s0, s1, syk_s0, syk_s1, match, steps, steps_sat
  );
`endif
endinterface

// File: rtl/no_syk_multi.sv
// Multi-valued tortoise/hare gene node: s0 steps once per HARE_RATIO start_s0
// pulses, s1 on every start_s1; flags armed state equality and counts hare steps.
// Latency one clock from pulse to state; no backpressure (pulses always accepted).
// Ports: clk, rst (async active-low), nos (no_syk_multi_if.slave).
// Optional macro NO_SYK_PERIOD_EN adds period / period_valid measurement.
module no_syk_multi #(
  parameter int STATE_W    = 1,
  parameter int HARE_RATIO = 2,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  no_syk_multi_if.slave nos
);

  localparam int PCNT_W = (HARE_RATIO > 1) ? $clog2(HARE_RATIO) : 1;
  localparam logic [PCNT_W-1:0] PCNT_RELOAD = PCNT_W'(HARE_RATIO - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE    = 1;
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE     = 1;

  logic [STATE_W-1:0] s0_q, s0_d;
  logic [STATE_W-1:0] s1_q, s1_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   steps_q, steps_d;

  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    pcnt_d  = pcnt_q;
    armed_d = armed_q;
    steps_d = steps_q;
    if (nos.reset_nos) begin
      // Re-initialisation wins over any step pulse in the same cycle.
      s0_d    = nos.init_state;
      s1_d    = nos.init_state;
      pcnt_d  = '0;
      armed_d = 1'b0;
      steps_d = '0;
    end else begin
      if (nos.start_s0) begin
        // pcnt == 0 means "this pulse is an update pulse".
        if (pcnt_q == '0) begin
          s0_d   = nos.il2r_s0;
          pcnt_d = PCNT_RELOAD;
        end else begin
          pcnt_d = pcnt_q - PCNT_ONE;
        end
      end
      if (nos.start_s1) begin
        s1_d    = nos.il2r_s1;
        armed_d = 1'b1;
        if (steps_q != CNT_MAX) steps_d = steps_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q    <= '0;
      s1_q    <= '0;
      pcnt_q  <= '0;
      armed_q <= 1'b0;
      steps_q <= '0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      pcnt_q  <= pcnt_d;
      armed_q <= armed_d;
      steps_q <= steps_d;
    end
  end

  // armed masks the trivially equal copies right after re-initialisation.
  logic match_w;
  assign match_w       = armed_q && (s0_q == s1_q);

  assign nos.s0        = s0_q;
  assign nos.s1        = s1_q;
  assign nos.syk_s0    = s0_q;
  assign nos.syk_s1    = s1_q;
  assign nos.match     = match_w;
  assign nos.steps     = steps_q;
  assign nos.steps_sat = (steps_q == CNT_MAX);

`ifdef NO_SYK_PERIOD_EN
  logic [STATE_W-1:0] ref_q, ref_d;
  logic               locked_q, locked_d;
  logic [CNT_W-1:0]   pper_q, pper_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               pvld_q, pvld_d;
  logic [CNT_W-1:0]   pper_inc;

  assign pper_inc = (pper_q == CNT_MAX) ? CNT_MAX : (pper_q + CNT_ONE);

  always_comb begin
    ref_d    = ref_q;
    locked_d = locked_q;
    pper_d   = pper_q;
    period_d = period_q;
    pvld_d   = pvld_q;
    if (nos.reset_nos) begin
      ref_d    = '0;
      locked_d = 1'b0;
      pper_d   = '0;
      period_d = '0;
      pvld_d   = 1'b0;
    end else if (!locked_q && match_w) begin
      // Capture the hare value at the first attractor hit; a hare pulse in
      // this same cycle is not part of the measured period.
      ref_d    = s1_q;
      locked_d = 1'b1;
      pper_d   = '0;
    end else if (locked_q && !pvld_q && nos.start_s1) begin
      pper_d = pper_inc;
      if (nos.il2r_s1 == ref_q) begin
        period_d = pper_inc;
        pvld_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q    <= '0;
      locked_q <= 1'b0;
      pper_q   <= '0;
      period_q <= '0;
      pvld_q   <= 1'b0;
    end else begin
      ref_q    <= ref_d;
      locked_q <= locked_d;
      pper_q   <= pper_d;
      period_q <= period_d;
      pvld_q   <= pvld_d;
    end
  end

  assign nos.period       = period_q;
  assign nos.period_valid = pvld_q;
`endif

endmodule
